slice_scheduler: RTL
====================

SLICE_SCHEDULER -- requirements
Module: slice_scheduler

Interface
REQ-001 SHALL have parameter ROTATIONAL_RES, default 1024, number of angular slices per revolution; THETA_W = clog2(ROTATIONAL_RES).
REQ-002 SHALL have parameter SCAN_RATE, default 32, number of HUB75 row addresses per slice; ADDR_W = clog2(SCAN_RATE).
REQ-003 SHALL have port clk_in, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, synchronous active-low reset.
REQ-005 SHALL have port dtheta_in, input, THETA_W, current angular slice index from the angle tracker.
REQ-006 SHALL have port fetch_req, output, 1, request to the frame manager to load column data for fetch_theta.
REQ-007 SHALL have port fetch_theta, output, THETA_W, slice being fetched.
REQ-008 SHALL have port fetch_ack, input, 1, frame manager has column data ready.
REQ-009 SHALL have port row_valid, output, 1, row_addr is valid for the HUB75 driver.
REQ-010 SHALL have port row_ready, input, 1, HUB75 driver accepts the row.
REQ-011 SHALL have port row_addr, output, ADDR_W, scan row address to drive.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 SHALL have port overrun_count, output, 16, slices dropped.
REQ-014 SHALL have port slice_count, output, 16, slices completed.

Function
REQ-015 SHALL implement states IDLE, FETCH and SEND.
REQ-016 SHALL register dtheta_in as prev_theta every cycle; a "change" is dtheta_in != prev_theta.
REQ-017 On a change in IDLE, SHALL go to FETCH with fetch_theta = dtheta_in; fetch_req is high from the next cycle (1-cycle latency).
REQ-018 In FETCH, fetch_req SHALL stay high and fetch_theta SHALL stay stable until fetch_ack; on fetch_ack, SHALL go to SEND with row_addr=0, and fetch_req SHALL drop the same edge.
REQ-019 In SEND, row_valid SHALL be high and row_addr stable until row_ready; each accepted row SHALL increment row_addr, back-to-back with no bubble.
REQ-020 Acceptance at row_addr = SCAN_RATE-1 SHALL complete the slice: slice_count increments, row_valid drops, and the next state is FETCH if a slice is pending, otherwise IDLE.
REQ-021 A change outside IDLE SHALL store pending_theta = dtheta_in and set pending_valid; if pending_valid was already set, overrun_count SHALL increment (newest slice wins).
REQ-022 Change on the slice-completing cycle SHALL go to FETCH with fetch_theta = dtheta_in and clear pending; overrun_count increments if pending_valid was set.
REQ-023 Entering FETCH from a pending slice SHALL clear pending_valid.
REQ-024 fetch_ack outside FETCH and row_ready outside SEND SHALL be ignored.
REQ-025 Counters SHALL saturate at 16'hFFFF.
REQ-026 row_addr SHALL wrap only by returning to 0 at the start of the next slice; it never exceeds SCAN_RATE-1.

Reset
REQ-027 When rst_in is low at a clock edge, the block SHALL set: state IDLE, fetch_req 0, fetch_theta 0, row_valid 0, row_addr 0, busy 0, pending_valid 0, prev_theta 0, both counters 0.
REQ-028 Reset mid-FETCH or mid-SEND SHALL abort the slice immediately without incrementing any counter; the first post-reset change starts a fresh slice.

Configuration
REQ-029 With SLICE_SCHEDULER_STATS_EN defined, overrun_count and slice_count SHALL be implemented per REQ-020..REQ-025.
REQ-030 Without SLICE_SCHEDULER_STATS_EN, both counter outputs SHALL be constant 0, no counter registers SHALL exist, and scheduling behaviour SHALL be unchanged.

Verification
REQ-031 Basic slice: reset, dtheta_in 0->5, fetch_ack after 3 cycles, row_ready held high -> fetch_theta=5, 32 rows 0..31 on consecutive cycles, slice_count=1, back to IDLE, busy=0.
REQ-032 Backpressure: row_ready toggles every other cycle -> row_addr holds while not ready, no skipped or repeated addresses.
REQ-033 Overrun: during SEND, dtheta_in steps 5->6->7 -> overrun_count=1, next fetch_theta=7.
REQ-034 Simultaneous: change to 9 on the row-31 acceptance cycle with pending=8 -> FETCH with fetch_theta=9, overrun_count incremented, pending cleared.
REQ-035 Reset mid-SEND at row_addr=10 -> all outputs at reset values next cycle, counters 0, no further fetch until a new change.
REQ-036 Build without SLICE_SCHEDULER_STATS_EN and rerun REQ-031 and REQ-033 -> identical handshakes, counters read 0.

Source files
------------

// File: rtl/slice_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : slice_scheduler_if                                 |
// | Description : Fetch and row handshakes between the slice         |
// |               scheduler, the frame manager and the HUB75 driver. |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface slice_scheduler_if #(
  parameter int THETA_W = 10,
  parameter int ADDR_W  = 5
);
  logic               fetch_req;
  logic [THETA_W-1:0] fetch_theta;
  logic               fetch_ack;
  logic               row_valid;
  logic               row_ready;
  logic [ADDR_W-1:0]  row_addr;

  // Scheduler side
  modport master (
    output fetch_req, fetch_theta, row_valid, row_addr,
    input  fetch_ack, row_ready
  );

  // Frame manager / HUB75 driver side
  modport slave (
    input  fetch_req, fetch_theta, row_valid, row_addr,
    output fetch_ack, row_ready
  );
endinterface
`default_nettype wire

// File: rtl/slice_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : slice_scheduler                                    |
// | Description : Tracks the angular slice index, fetches column     |
// |               data for each new slice and streams SCAN_RATE row  |
// |               addresses to the HUB75 driver. One slice may be    |
// |               queued while busy; newer slices replace it.        |
// | Option      : define SLICE_SCHEDULER_STATS_EN to build the       |
// |               slice/overrun counters (otherwise they read 0).    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module slice_scheduler #(
  parameter  int ROTATIONAL_RES = 1024,
  parameter  int SCAN_RATE      = 32,
  localparam int THETA_W        = $clog2(ROTATIONAL_RES),
  localparam int ADDR_W         = $clog2(SCAN_RATE)
) (
  input  wire                clk_in,
  input  wire                rst_in,
  input  wire  [THETA_W-1:0] dtheta_in,
  slice_scheduler_if.master  bus,
  output logic               busy,
  output logic [15:0]        overrun_count,
  output logic [15:0]        slice_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(SCAN_RATE - 1);

  logic [1:0]         state_q,         state_d;
  logic               fetch_req_q,     fetch_req_d;
  logic [THETA_W-1:0] fetch_theta_q,   fetch_theta_d;
  logic               row_valid_q,     row_valid_d;
  logic [ADDR_W-1:0]  row_addr_q,      row_addr_d;
  logic               pending_valid_q, pending_valid_d;
  logic [THETA_W-1:0] pending_theta_q, pending_theta_d;
  logic [THETA_W-1:0] prev_theta_q;

  logic change;
  logic slice_done;

  assign change     = (dtheta_in != prev_theta_q);
  assign slice_done = (state_q == S_SEND) && bus.row_ready && (row_addr_q == ROW_LAST);

  assign busy            = (state_q != S_IDLE);
  assign bus.fetch_req   = fetch_req_q;
  assign bus.fetch_theta = fetch_theta_q;
  assign bus.row_valid   = row_valid_q;
  assign bus.row_addr    = row_addr_q;

  // Next-state logic: slice sequencing plus the one-deep pending slot
  always_comb begin
    state_d         = state_q;
    fetch_req_d     = fetch_req_q;
    fetch_theta_d   = fetch_theta_q;
    row_valid_d     = row_valid_q;
    row_addr_d      = row_addr_q;
    pending_valid_d = pending_valid_q;
    pending_theta_d = pending_theta_q;

    case (state_q)
      S_IDLE: begin
        if (change) begin
          state_d       = S_FETCH;
          fetch_req_d   = 1'b1;
          fetch_theta_d = dtheta_in;
        end
      end
      S_FETCH: begin
        if (bus.fetch_ack) begin
          state_d     = S_SEND;
          fetch_req_d = 1'b0;
          row_valid_d = 1'b1;
          row_addr_d  = '0;
        end
      end
      S_SEND: begin
        if (bus.row_ready) begin
          if (row_addr_q == ROW_LAST) begin
            row_valid_d = 1'b0;
            // A change on the completing cycle beats whatever was queued
            if (change) begin
              state_d       = S_FETCH;
              fetch_req_d   = 1'b1;
              fetch_theta_d = dtheta_in;
            end else if (pending_valid_q) begin
              state_d       = S_FETCH;
              fetch_req_d   = 1'b1;
              fetch_theta_d = pending_theta_q;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            row_addr_d = row_addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        fetch_req_d = 1'b0;
        row_valid_d = 1'b0;
      end
    endcase

    // Queue slices that arrive while busy; the newest one wins
    if (change && (state_q != S_IDLE)) begin
      pending_valid_d = 1'b1;
      pending_theta_d = dtheta_in;
    end
    // Completing a slice always consumes or supersedes the queued slot
    if (slice_done) begin
      pending_valid_d = 1'b0;
    end
  end

  // Scheduler state registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q         <= S_IDLE;
      fetch_req_q     <= 1'b0;
      fetch_theta_q   <= '0;
      row_valid_q     <= 1'b0;
      row_addr_q      <= '0;
      pending_valid_q <= 1'b0;
      pending_theta_q <= '0;
      prev_theta_q    <= '0;
    end else begin
      state_q         <= state_d;
      fetch_req_q     <= fetch_req_d;
      fetch_theta_q   <= fetch_theta_d;
      row_valid_q     <= row_valid_d;
      row_addr_q      <= row_addr_d;
      pending_valid_q <= pending_valid_d;
      pending_theta_q <= pending_theta_d;
      prev_theta_q    <= dtheta_in;
    end
  end

`ifdef SLICE_SCHEDULER_STATS_EN
  logic [15:0] slice_count_q,   slice_count_d;
  logic [15:0] overrun_count_q, overrun_count_d;
  logic        overrun;

  // A slice is dropped whenever a new one arrives while one is already queued
  assign overrun = change && (state_q != S_IDLE) && pending_valid_q;

  // Saturating statistics counters
  always_comb begin
    slice_count_d   = slice_count_q;
    overrun_count_d = overrun_count_q;
    if (slice_done && (slice_count_q != 16'hFFFF)) begin
      slice_count_d = slice_count_q + 16'd1;
    end
    if (overrun && (overrun_count_q != 16'hFFFF)) begin
      overrun_count_d = overrun_count_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      slice_count_q   <= '0;
      overrun_count_q <= '0;
    end else begin
      slice_count_q   <= slice_count_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign slice_count   = slice_count_q;
  assign overrun_count = overrun_count_q;
`else
  assign slice_count   = 16'd0;
  assign overrun_count = 16'd0;
`endif

endmodule
`default_nettype wire
